// File: rtl/vend_pkg.sv
// Shared definitions for the vending change dispenser: coin indices, coin
// values in 5-cent units, and the dispenser FSM state encoding.
package vend_pkg;

  localparam int UNIT_CENTS = 5;

  localparam int COIN_25 = 2;
  localparam int COIN_10 = 1;
  localparam int COIN_5  = 0;

  localparam int VAL_25 = 5;
  localparam int VAL_10 = 2;
  localparam int VAL_5  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PULSE,
    ST_GAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter that stops at zero. tc flags the final cycle of a
// loaded interval, so loading N-1 yields an interval of exactly N cycles.
module vend_pulse_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/vend_change_dispenser.sv
// Pays out a change request as timed one-hot hopper pulses, largest coin
// first, skipping empty hoppers, and reports any unpaid remainder.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W     = 6,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic [2:0]       hopper_empty,
  output logic [2:0]       coin_pulse,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] shortfall
);

  localparam int TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] shortfall_q, shortfall_d;
  logic [2:0]       coin_pulse_q, coin_pulse_d;
  logic             done_q, done_d;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_tc;
  logic [2:0]       pick;

  function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] onehot);
    logic [AMT_W-1:0] v;
    v = '0;
    if (onehot[COIN_25])      v = AMT_W'(VAL_25);
    else if (onehot[COIN_10]) v = AMT_W'(VAL_10);
    else if (onehot[COIN_5])  v = AMT_W'(VAL_5);
    return v;
  endfunction

  vend_pulse_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    shortfall_d  = shortfall_q;
    coin_pulse_d = coin_pulse_q;
    done_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    pick         = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          remaining_d = req_amount;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        // Coin value never exceeds remaining, so the later subtract cannot wrap.
        if (remaining_q >= AMT_W'(VAL_25) && !hopper_empty[COIN_25])
          pick[COIN_25] = 1'b1;
        else if (remaining_q >= AMT_W'(VAL_10) && !hopper_empty[COIN_10])
          pick[COIN_10] = 1'b1;
        else if (remaining_q >= AMT_W'(VAL_5) && !hopper_empty[COIN_5])
          pick[COIN_5] = 1'b1;

        if (pick != 3'b000) begin
          coin_pulse_d = pick;
          tmr_load     = 1'b1;
          tmr_val      = TMR_W'(PULSE_CYC - 1);
          state_d      = ST_PULSE;
        end else begin
          shortfall_d = remaining_q;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_PULSE: begin
        if (tmr_tc) begin
          remaining_d  = remaining_q - coin_value(coin_pulse_q);
          coin_pulse_d = 3'b000;
          tmr_load     = 1'b1;
          tmr_val      = TMR_W'(GAP_CYC - 1);
          state_d      = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_tc) state_d = ST_SELECT;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        coin_pulse_d = 3'b000;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      shortfall_q  <= '0;
      coin_pulse_q <= 3'b000;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      shortfall_q  <= shortfall_d;
      coin_pulse_q <= coin_pulse_d;
      done_q       <= done_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign coin_pulse = coin_pulse_q;
  assign done       = done_q;
  assign shortfall  = shortfall_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed scoreboard bench for vend_change_dispenser: the driver queues the
// expected coin pulses and done strobe per request; a monitor checks them.
module tb_vend_change_dispenser;

  localparam int AMT_W = 6;
  localparam int PC    = 4;
  localparam int GC    = 4;
  localparam int CPC   = 1 + PC + GC;

  localparam logic [2:0] C25 = 3'b100;
  localparam logic [2:0] C10 = 3'b010;
  localparam logic [2:0] C5  = 3'b001;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready;
  logic [2:0]       hopper_empty = 3'b000;
  logic [2:0]       coin_pulse;
  logic             busy;
  logic             done;
  logic [AMT_W-1:0] shortfall;

  vend_change_dispenser #(.AMT_W(AMT_W), .PULSE_CYC(PC), .GAP_CYC(GC)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_amount   (req_amount),
    .req_ready    (req_ready),
    .hopper_empty (hopper_empty),
    .coin_pulse   (coin_pulse),
    .busy         (busy),
    .done         (done),
    .shortfall    (shortfall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               is_done;
    logic [2:0]       coin;
    logic [AMT_W-1:0] sf;
    int               cyc;
  } ev_t;

  ev_t sbq[$];
  ev_t mon_e;
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops one expected event per observed pulse start or done strobe.
  logic [2:0] prev_p = 3'b000;
  int         run_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_p  = 3'b000;
      run_len = 0;
    end else begin
      check("pulse_onehot", 32'($countones(coin_pulse) <= 1), 32'd1);
      if (coin_pulse != 3'b000 && coin_pulse !== prev_p) begin
        if (sbq.size() == 0) begin
          flag("unexpected_pulse");
        end else begin
          mon_e = sbq.pop_front();
          check("ev_is_pulse", 32'(mon_e.is_done), 32'd0);
          check("pulse_coin", 32'(coin_pulse), 32'(mon_e.coin));
          check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
      if (coin_pulse != 3'b000) begin
        run_len++;
      end else if (prev_p != 3'b000) begin
        check("pulse_width", 32'(run_len), 32'(PC));
        run_len = 0;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          flag("unexpected_done");
        end else begin
          mon_e = sbq.pop_front();
          check("ev_is_done", 32'(mon_e.is_done), 32'd1);
          check("done_shortfall", 32'(shortfall), 32'(mon_e.sf));
          check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
      prev_p = coin_pulse;
    end
  end

  task automatic issue(input logic [AMT_W-1:0] amt, output int a);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) flag("ready_timeout");
    req_valid  = 1'b1;
    req_amount = amt;
    a = cyc;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_amount = 6'h2a;
  endtask

  task automatic push_coin(input int a, input int idx, input logic [2:0] coin);
    ev_t e;
    e.is_done = 1'b0; e.coin = coin; e.sf = '0; e.cyc = a + 2 + CPC * idx;
    sbq.push_back(e);
  endtask

  task automatic push_done(input int a, input int n, input logic [AMT_W-1:0] sf);
    ev_t e;
    e.is_done = 1'b1; e.coin = 3'b000; e.sf = sf; e.cyc = a + 2 + CPC * n;
    sbq.push_back(e);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(sbq.size() == 0 && req_ready) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0 || !req_ready) begin
      flag("idle_timeout");
      sbq.delete();
    end
  endtask

  initial begin
    int a;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pulse", 32'(coin_pulse), 32'd0);
    check("rst_shortfall", 32'(shortfall), 32'd0);
    rst = 1'b0;

    // 8 units, all full: 25c,10c,5c; a request raised while busy is ignored
    issue(6'd8, a);
    push_coin(a, 0, C25); push_coin(a, 1, C10); push_coin(a, 2, C5);
    push_done(a, 3, 6'd0);
    wait_to(a + 1);
    check("busy_in_select", 32'(busy), 32'd1);
    check("ready_low_busy", 32'(req_ready), 32'd0);
    wait_to(a + 5);
    req_valid = 1'b1; req_amount = 6'd20;
    wait_to(a + 8);
    req_valid = 1'b0;
    wait_idle();

    // 0 units: immediate done, ready the cycle after
    issue(6'd0, a);
    push_done(a, 0, 6'd0);
    wait_to(a + 3);
    check("zero_ready_a3", 32'(req_ready), 32'd1);
    wait_idle();

    // 5 units, 25c hopper empty: 10c,10c,5c
    hopper_empty = 3'b100;
    issue(6'd5, a);
    push_coin(a, 0, C10); push_coin(a, 1, C10); push_coin(a, 2, C5);
    push_done(a, 3, 6'd0);
    wait_idle();

    // 1 unit, 5c hopper empty: shortfall 1
    hopper_empty = 3'b001;
    issue(6'd1, a);
    push_done(a, 0, 6'd1);
    wait_idle();
    hopper_empty = 3'b000;

    // 7 units, 10c empties during the first pulse: 25c,5c,5c
    issue(6'd7, a);
    push_coin(a, 0, C25); push_coin(a, 1, C5); push_coin(a, 2, C5);
    push_done(a, 3, 6'd0);
    wait_to(a + 3);
    hopper_empty = 3'b010;
    wait_idle();
    hopper_empty = 3'b000;

    // 7 units, everything empties during the first pulse: shortfall 2
    issue(6'd7, a);
    push_coin(a, 0, C25);
    push_done(a, 1, 6'd2);
    wait_to(a + 3);
    hopper_empty = 3'b111;
    wait_idle();
    check("shortfall_hold", 32'(shortfall), 32'd2);
    hopper_empty = 3'b000;

    // 63 units: twelve 25c, one 10c, one 5c
    issue(6'd63, a);
    for (int i = 0; i < 12; i++) push_coin(a, i, C25);
    push_coin(a, 12, C10); push_coin(a, 13, C5);
    push_done(a, 14, 6'd0);
    wait_idle();

    // Reset mid-pulse drops coin_pulse asynchronously and suppresses done
    issue(6'd7, a);
    push_coin(a, 0, C25);
    wait_to(a + 3);
    check("pre_rst_pulse", 32'(coin_pulse), 32'(C25));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pulse", 32'(coin_pulse), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_shortfall", 32'(shortfall), 32'd0);
    repeat (10) @(negedge clk);

    // Fresh request after reset: one 10c
    issue(6'd2, a);
    push_coin(a, 0, C10);
    push_done(a, 1, 6'd0);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
- Output end of the vending machine's coin path: the vending controller computes change owed, and this block pays it out.
- Accepts one change request (amount in 5-cent units) over a valid/ready handshake.
- Drives timed one-hot pulses to three coin hoppers (25c, 10c, 5c), always choosing the largest coin first and skipping empty hoppers.
- Reports completion, plus any shortfall that could not be paid.

Parameters:
- AMT_W, 6: width of the change amount in 5-cent units (max 63 units = 3.15).
- PULSE_CYC, 4: cycles each hopper pulse is held high; must be >= 1.
- GAP_CYC, 4: idle cycles after each pulse before the next coin selection; must be >= 1.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  change request present.
- req_amount  input  AMT_W  change owed, in 5-cent units; sampled on accept.
- req_ready  output  1  block idle and able to accept a request.
- hopper_empty  input  3  per-hopper empty flag; bit2=25c, bit1=10c, bit0=5c.
- coin_pulse  output  3  one-hot dispense pulse, same bit mapping as hopper_empty.
- busy  output  1  a request is being serviced (any state except IDLE).
- done  output  1  one-cycle strobe at end of request.
- shortfall  output  AMT_W  unpaid remainder of the last request; valid from done onward.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- While rst is high: state=IDLE, coin_pulse=0, done=0, busy=0, shortfall=0, remaining=0, timer=0. req_ready=1 once in IDLE.
- FSM states: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE: req_ready=1.
  - On req_valid && req_ready: latch remaining<=req_amount and go to SELECT.
  - req_amount is not sampled at any other time.
- SELECT (exactly 1 cycle): evaluate in priority order, using hopper_empty sampled this cycle.
  - remaining>=5 and !hopper_empty[2]: pick 25c.
  - else remaining>=2 and !hopper_empty[1]: pick 10c.
  - else remaining>=1 and !hopper_empty[0]: pick 5c.
  - If a coin is picked: go to PULSE, load timer=PULSE_CYC-1.
  - If remaining==0, or no coin is pickable: go to DONE and register shortfall<=remaining.
- PULSE: coin_pulse=one-hot of the chosen coin, held exactly PULSE_CYC cycles.
  - On the last cycle: remaining<=remaining-value (5/2/1), go to GAP, load timer=GAP_CYC-1.
- GAP: coin_pulse=0 for exactly GAP_CYC cycles, then return to SELECT.
- DONE (1 cycle): done=1, then go to IDLE.
- Output timing:
  - busy=1 in SELECT/PULSE/GAP/DONE.
  - coin_pulse is registered; zero outside PULSE.
  - shortfall holds its value until the next DONE or reset.
- Timing: with acceptance edge A, the first SELECT occurs in cycle A+1. Each coin costs 1+PULSE_CYC+GAP_CYC cycles. After N coins, done is high in cycle A+2+N*(1+PULSE_CYC+GAP_CYC).
- Arithmetic: remaining never underflows, because coin choice guarantees value<=remaining. Comparisons are unsigned at AMT_W.
- hopper_empty changing during PULSE/GAP has no effect until the next SELECT. A hopper emptying mid-request only redirects later selections.
- req_valid asserted while busy is ignored; the requester must hold it until req_ready.
- Reset during PULSE drops coin_pulse in the same instant (asynchronously). The in-flight request is discarded and done is not issued.

Decomposition:
- Shared package vend_pkg holds:
  - coin index constants COIN_25=2, COIN_10=1, COIN_5=0;
  - coin values in units (5, 2, 1);
  - the FSM state enum;
  - the unit-of-currency constant (5 cents).
- One natural sub-module: vend_pulse_timer, a loadable down-counter with a terminal-count flag, used for both PULSE and GAP timing.

Test Plan:
- Amount 8, all hoppers full, defaults -> pulses 25c, 10c, 5c in that order, each high 4 cycles with 4-cycle gaps. done in cycle A+29; shortfall=0.
- Amount 0 -> no coin_pulse; done in cycle A+2; shortfall=0; req_ready=1 in cycle A+3.
- Amount 5, hopper_empty=3'b100 -> pulses 10c, 10c, 5c; shortfall=0; done in cycle A+29.
- Amount 1, hopper_empty=3'b001 -> no pulses; done in cycle A+2; shortfall=1.
- Amount 7: assert hopper_empty[1] during the first 25c pulse -> 25c then 5c, 5c; shortfall=0. Repeat with all hoppers going empty after the 25c -> shortfall=2.
- rst raised mid-PULSE of a 25c coin -> coin_pulse=0 immediately, no done. After release: req_ready=1 and busy=0, and a fresh request of 2 pays one 10c.
